vram_arbiter: RTL and testbench

Arbiter and sequencer for the single-port text video RAM shared by the display path and a host write/read port. It sits between the pixel decoder's character/attribute fetches and the console writer. The display always wins the RAM, and every display fetch returns on a fixed 1-cycle schedule. The block also contains a clear-screen engine that fills the whole RAM using only cycles the display leaves free.

---
 rtl/vram_arbiter_if.sv | 56 +++++
 rtl/vram_arbiter.sv | 108 ++++++++++
 tb/tb_vram_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: bundles the display fetch port, the host access port,
// the clear-screen control and the single-port RAM bus of vram_arbiter.
//
// Handshakes:
//   display: disp_req is a one-cycle pulse that is always served; disp_valid
//            with disp_rdata follows exactly one cycle later.
//   host:    host_valid plus every other host_* field is held stable until a
//            cycle in which host_ready=1; that cycle is the transfer. A read
//            returns host_rvalid with host_rdata on the following cycle.
//   clear:   clr_start is a pulse; clr_busy covers the fill and clr_done
//            pulses once, in the cycle clr_busy falls.
//   RAM:     mem_en/mem_we/mem_addr/mem_wdata issue an access; read data
//            appears on mem_rdata one cycle after a read issue.
//
// Modports: slave = arbiter side, master = clients plus RAM side.
interface vram_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_rdata;

  logic              host_valid;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ready;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic              clr_start;
  logic              clr_busy;
  logic              clr_done;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  disp_req, disp_addr, host_valid, host_we, host_addr, host_wdata,
           clr_start, mem_rdata,
    output disp_valid, disp_rdata, host_ready, host_rvalid, host_rdata,
           clr_busy, clr_done, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output disp_req, disp_addr, host_valid, host_we, host_addr, host_wdata,
           clr_start, mem_rdata,
    input  disp_valid, disp_rdata, host_ready, host_rvalid, host_rdata,
           clr_busy, clr_done, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port text RAM between the display fetch
// path, a clear-screen engine and a host read/write port.
// Fixed priority each cycle: display > clear (CLEAR only) > host (IDLE only).
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   bus           vram_arbiter_if slave view (display, host, clear, RAM)
//   dbg_state     current FSM state (0 = IDLE, 1 = CLEAR)
module vram_arbiter #(
  parameter int              ADDR_W   = 12,
  parameter int              DATA_W   = 16,
  parameter int              DEPTH    = 2400,
  parameter logic [DATA_W-1:0] CLR_WORD = 16'h0720
) (
  input  logic                  clk,
  input  logic                  reset_n,
  vram_arbiter_if.slave         bus,
  output logic                  dbg_state
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;
  // Owner of the read issued in the previous cycle, steering mem_rdata.
  typedef enum logic [1:0] {TAG_NONE = 2'd0, TAG_DISP = 2'd1, TAG_HOST = 2'd2} tag_t;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_t            state, state_n;
  tag_t              tag, tag_n;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_n;
  logic              clr_done_q, clr_done_n;

  logic              en_c, we_c, ready_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] wdata_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      tag        <= TAG_NONE;
      clr_ptr    <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state      <= state_n;
      tag        <= tag_n;
      clr_ptr    <= clr_ptr_n;
      clr_done_q <= clr_done_n;
    end
  end

  always_comb begin
    state_n    = state;
    tag_n      = TAG_NONE;
    clr_ptr_n  = clr_ptr;
    clr_done_n = 1'b0;
    en_c       = 1'b0;
    we_c       = 1'b0;
    ready_c    = 1'b0;
    addr_c     = '0;
    wdata_c    = '0;

    if (bus.disp_req) begin
      en_c   = 1'b1;
      addr_c = bus.disp_addr;
      tag_n  = TAG_DISP;
    end else if (state == CLEAR) begin
      en_c    = 1'b1;
      we_c    = 1'b1;
      addr_c  = clr_ptr;
      wdata_c = CLR_WORD;
      if (clr_ptr == LAST_PTR) begin
        state_n    = IDLE;
        clr_done_n = 1'b1;
      end else begin
        clr_ptr_n = clr_ptr + 1'b1;
      end
    end else if (bus.host_valid) begin
      ready_c = 1'b1;
      en_c    = 1'b1;
      we_c    = bus.host_we;
      addr_c  = bus.host_addr;
      wdata_c = bus.host_wdata;
      tag_n   = bus.host_we ? TAG_NONE : TAG_HOST;
    end

    // A start in IDLE still lets this cycle's host slot through above.
    if (state == IDLE && bus.clr_start) begin
      state_n   = CLEAR;
      clr_ptr_n = '0;
    end
  end

  // Gating with reset_n keeps the RAM and host quiet while reset is held,
  // even if a client keeps requesting.
  assign bus.mem_en      = en_c & reset_n;
  assign bus.host_ready  = ready_c & reset_n;
  assign bus.mem_we      = we_c;
  assign bus.mem_addr    = addr_c;
  assign bus.mem_wdata   = wdata_c;

  assign bus.disp_valid  = (tag == TAG_DISP);
  assign bus.host_rvalid = (tag == TAG_HOST);
  assign bus.disp_rdata  = bus.mem_rdata;
  assign bus.host_rdata  = bus.mem_rdata;

  assign bus.clr_busy    = (state == CLEAR);
  assign bus.clr_done    = clr_done_q;
  assign dbg_state       = (state == CLEAR);

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed and randomized bench for vram_arbiter (DEPTH=16).
// A transaction-level model tracks expected RAM contents, expected read
// returns (exp_q) and the clear engine's remaining work; every cycle the
// DUT's outputs are compared against it.
module tb_vram_arbiter;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int RAM_N  = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] CLR = 16'h0720;

  logic clk;
  logic reset_n;
  logic dbg_state;

  vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CLR_WORD(CLR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM environment ----------------
  logic [DATA_W-1:0] ram [0:RAM_N-1];
  logic [DATA_W-1:0] ram_q;
  assign bus.mem_rdata = ram_q;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
      else            ram_q <= ram[bus.mem_addr];
    end
  end

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] exp_mem [0:RAM_N-1];
  logic [DATA_W-1:0] exp_q[$];
  bit  m_clr_active, m_done, m_disp_ret, m_host_ret, last_grant;
  int  m_clr_left;   // clear words still to write
  int  m_clr_cnt;    // next clear address
  int  busy_cycles;
  int  checks, errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    bus.disp_req   = 1'b0;
    bus.disp_addr  = '0;
    bus.host_valid = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    bus.clr_start  = 1'b0;
  endtask

  // One clock cycle: inputs are already set; check at negedge, advance model,
  // return to posedge+1 for the next drive.
  task automatic step();
    bit exp_ready, exp_en;
    logic [DATA_W-1:0] d;
    @(negedge clk);
    exp_ready = bus.host_valid && !bus.disp_req && !m_clr_active;
    exp_en    = bus.disp_req || m_clr_active || exp_ready;
    chk("host_ready",  32'(bus.host_ready),  32'(exp_ready));
    chk("mem_en",      32'(bus.mem_en),      32'(exp_en));
    chk("disp_valid",  32'(bus.disp_valid),  32'(m_disp_ret));
    chk("host_rvalid", 32'(bus.host_rvalid), 32'(m_host_ret));
    chk("valid_excl",  32'(bus.disp_valid & bus.host_rvalid), 32'd0);
    if (m_disp_ret || m_host_ret) begin
      if (exp_q.size() == 0) chk("exp_q_underflow", 32'd1, 32'd0);
      else begin
        d = exp_q.pop_front();
        if (m_disp_ret) chk("disp_rdata", 32'(bus.disp_rdata), 32'(d));
        else            chk("host_rdata", 32'(bus.host_rdata), 32'(d));
      end
    end
    chk("clr_busy",  32'(bus.clr_busy), 32'(m_clr_active));
    chk("clr_done",  32'(bus.clr_done), 32'(m_done));
    chk("dbg_state", 32'(dbg_state),    32'(m_clr_active));
    if (bus.clr_busy) busy_cycles++;

    last_grant = exp_ready;
    m_disp_ret = bus.disp_req;
    m_host_ret = exp_ready && !bus.host_we;
    m_done     = 1'b0;
    if (bus.disp_req) begin
      exp_q.push_back(exp_mem[bus.disp_addr]);
    end else if (m_clr_active) begin
      exp_mem[m_clr_cnt] = CLR;
      m_clr_cnt++;
      m_clr_left--;
    end else if (exp_ready) begin
      if (bus.host_we) exp_mem[bus.host_addr] = bus.host_wdata;
      else             exp_q.push_back(exp_mem[bus.host_addr]);
    end
    if (m_clr_active && m_clr_left == 0) begin
      m_clr_active = 1'b0;
      m_done       = 1'b1;
    end else if (!m_clr_active && bus.clr_start) begin
      m_clr_active = 1'b1;
      m_clr_left   = DEPTH;
      m_clr_cnt    = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // Host access held until granted, then released for one idle cycle.
  task automatic host_op(input bit we, input int addr, input logic [DATA_W-1:0] data);
    int n;
    bus.host_valid = 1'b1;
    bus.host_we    = we;
    bus.host_addr  = ADDR_W'(addr);
    bus.host_wdata = data;
    n = 0;
    last_grant = 1'b0;
    while (!last_grant && n < 60) begin
      step();
      n++;
    end
    if (!last_grant) chk("host_grant_timeout", 32'd0, 32'd1);
    bus.host_valid = 1'b0;
    step();
  endtask

  task automatic disp_read(input int addr);
    bus.disp_req  = 1'b1;
    bus.disp_addr = ADDR_W'(addr);
    step();
    bus.disp_req  = 1'b0;
  endtask

  task automatic model_reset();
    m_clr_active = 1'b0;
    m_done       = 1'b0;
    m_disp_ret   = 1'b0;
    m_host_ret   = 1'b0;
    m_clr_left   = 0;
    exp_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_en"},      32'(bus.mem_en),      32'd0);
    chk({tag, "_host_ready"},  32'(bus.host_ready),  32'd0);
    chk({tag, "_disp_valid"},  32'(bus.disp_valid),  32'd0);
    chk({tag, "_host_rvalid"}, 32'(bus.host_rvalid), 32'd0);
    chk({tag, "_clr_busy"},    32'(bus.clr_busy),    32'd0);
    chk({tag, "_clr_done"},    32'(bus.clr_done),    32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < RAM_N; i++) begin
      ram[i]     = '0;
      exp_mem[i] = '0;
    end
    ram_q = '0;
    model_reset();
    busy_cycles = 0;
    set_idle();

    // Reset with clients requesting: RAM and host must stay quiet.
    reset_n = 1'b0;
    bus.disp_req   = 1'b1;
    bus.host_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset_dbg_state", 32'(dbg_state), 32'd0);
    set_idle();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();

    // Display-only read of a preloaded word.
    host_op(1'b1, 5, 16'h1F41);
    disp_read(5);
    step();

    // Collision: held host write loses to display, wins next cycle.
    bus.host_valid = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = 12'd7;
    bus.host_wdata = 16'hABCD;
    bus.disp_req   = 1'b1;
    bus.disp_addr  = 12'd5;
    step();
    chk("collision_ready_lost", 32'(last_grant), 32'd0);
    bus.disp_req = 1'b0;
    step();
    chk("collision_ready_next", 32'(last_grant), 32'd1);
    bus.host_valid = 1'b0;
    step();
    host_op(1'b0, 7, '0);

    // Alternating display/host reads.
    host_op(1'b1, 3, 16'h3333);
    host_op(1'b1, 4, 16'h4444);
    for (int i = 0; i < 3; i++) begin
      disp_read(3);
      bus.host_valid = 1'b1;
      bus.host_we    = 1'b0;
      bus.host_addr  = 12'd4;
      step();
      bus.host_valid = 1'b0;
    end
    step();

    // Clear with no display traffic.
    busy_cycles = 0;
    bus.clr_start = 1'b1;
    step();
    bus.clr_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.host_valid = 1'b1;     // must never be granted during the clear
      bus.host_we    = 1'b0;
      bus.host_addr  = 12'd9;
      if (!m_clr_active) bus.host_valid = 1'b0;
      step();
    end
    bus.host_valid = 1'b0;
    chk("clear_busy_cycles", 32'(busy_cycles), 32'd16);
    for (int a = 0; a < DEPTH; a++) host_op(1'b0, a, '0);

    // Clear with a display fetch every 8th cycle.
    busy_cycles = 0;
    bus.clr_start = 1'b1;
    step();
    bus.clr_start = 1'b0;
    for (int i = 0; i < 24; i++) begin
      bus.disp_req  = ((i % 8) == 7);
      bus.disp_addr = ADDR_W'(i % 6);
      step();
    end
    bus.disp_req = 1'b0;
    step();
    chk("clear_disp_busy_cycles", 32'(busy_cycles), 32'd18);

    // Reset mid-clear: distinct pattern first so the partial fill is visible.
    for (int a = 0; a < DEPTH; a++) host_op(1'b1, a, 16'h5A00 + 16'(a));
    bus.clr_start = 1'b1;
    step();
    bus.clr_start = 1'b0;
    repeat (6) step();
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midclr");
    model_reset();
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) step();
    for (int a = 0; a < DEPTH; a++) host_op(1'b0, a, '0);
    busy_cycles = 0;
    bus.clr_start = 1'b1;
    step();
    bus.clr_start = 1'b0;
    repeat (18) step();
    chk("reclear_busy_cycles", 32'(busy_cycles), 32'd16);
    for (int a = 0; a < DEPTH; a++) host_op(1'b0, a, '0);

    // Randomized traffic: host requests held until granted.
    begin
      bit pend;
      pend = 1'b0;
      for (int i = 0; i < 600; i++) begin
        if (!pend && $urandom_range(0, 2) == 0) begin
          pend = 1'b1;
          bus.host_valid = 1'b1;
          bus.host_we    = $urandom_range(0, 1) == 1;
          bus.host_addr  = ADDR_W'($urandom_range(0, 31));
          bus.host_wdata = DATA_W'($urandom);
        end
        bus.disp_req  = $urandom_range(0, 3) == 0;
        bus.disp_addr = ADDR_W'($urandom_range(0, 31));
        bus.clr_start = $urandom_range(0, 99) == 0;
        step();
        if (last_grant) begin
          pend = 1'b0;
          bus.host_valid = 1'b0;
        end
      end
      set_idle();
      repeat (25) step();
      for (int a = 0; a < 32; a++) host_op(1'b0, a, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
